// File: rtl/riscv_cpu_pkg.sv
// rtl/riscv_cpu_pkg.sv - shared types for the riscv_cpu load/store path
package riscv_cpu_pkg;

    typedef enum logic [1:0] {
        DT_WORD = 2'b00,
        DT_HALF = 2'b01,
        DT_BYTE = 2'b10
    } data_type_e;

    typedef enum logic {
        LSU_IDLE     = 1'b0,
        LSU_WAIT_GNT = 1'b1
    } lsu_state_e;

    typedef struct packed {
        logic       we;
        data_type_e dtype;
        logic       sign;
        logic [1:0] off;
    } lsu_pending_t;

    function automatic logic [3:0] lsu_be(input logic [1:0] dtype, input logic [1:0] off);
        case (dtype)
            2'b10:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/lsu_resp_fifo.sv
// rtl/lsu_resp_fifo.sv - in-order pending-response FIFO with same-cycle push/pop
module lsu_resp_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  T              push_data_i,
    input  logic          pop_i,
    output T              pop_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (count_o == CW'(DEPTH));
    assign empty_o    = (count_o == '0);
    assign do_pop     = pop_i && !empty_o;
    assign do_push    = push_i && (!full_o || do_pop);
    assign pop_data_o = mem[rd_ptr];

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count_o <= count_o + CW'(1);
                2'b01:   count_o <= count_o - CW'(1);
                default: count_o <= count_o;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage LSU: request FSM, byte lanes, load extension
module load_store_unit
    import riscv_cpu_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    output logic                    data_req_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    output logic [DATA_WIDTH-1:0]   data_addr_o,
    output logic                    data_we_o,
    output logic [DATA_WIDTH/8-1:0] data_be_o,
    output logic [DATA_WIDTH-1:0]   data_wdata_o,
    input  logic [DATA_WIDTH-1:0]   data_rdata_i,
    input  logic                    data_req_mem_i,
    input  logic                    data_we_mem_i,
    input  logic [1:0]              data_type_mem_i,
    input  logic                    data_sign_ext_mem_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_mem_i,
    input  logic [DATA_WIDTH-1:0]   operand_a_mem_i,
    input  logic [DATA_WIDTH-1:0]   operand_b_mem_i,
    output logic [DATA_WIDTH-1:0]   data_rdata_mem_o,
    output logic                    data_rvalid_mem_o,
    output logic                    lsu_busy_o,
    output logic                    misaligned_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    lsu_state_e                state;
    logic [DATA_WIDTH-1:0]     ea;
    logic [1:0]                off;
    logic                      mis_access;
    lsu_pending_t              cur_info;
    lsu_pending_t              lat_info;
    lsu_pending_t              push_info;
    lsu_pending_t              head;
    logic [DATA_WIDTH-1:0]     lat_addr;
    logic [DATA_WIDTH/8-1:0]   lat_be;
    logic [DATA_WIDTH-1:0]     lat_wdata;
    logic                      req_int;
    logic                      busy_int;
    logic                      mis_int;
    logic                      push;
    logic                      pop;
    logic [CW-1:0]             fifo_count;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [DATA_WIDTH-1:0]     shifted;
    logic [DATA_WIDTH-1:0]     ext;

    assign ea  = operand_a_mem_i + operand_b_mem_i;
    assign off = ea[1:0];

    always_comb begin
        case (data_type_mem_i)
            2'b00:   mis_access = (off != 2'b00);
            2'b01:   mis_access = off[0];
            2'b10:   mis_access = 1'b0;
            default: mis_access = 1'b1;
        endcase
    end

    assign cur_info = '{we: data_we_mem_i, dtype: data_type_e'(data_type_mem_i),
                        sign: data_sign_ext_mem_i, off: off};

    // WAIT_GNT replays the latched request so the bus sees stable address/data until granted.
    always_comb begin
        req_int      = 1'b0;
        busy_int     = 1'b0;
        mis_int      = 1'b0;
        data_addr_o  = {ea[DATA_WIDTH-1:2], 2'b00};
        data_we_o    = data_we_mem_i;
        data_be_o    = lsu_be(data_type_mem_i, off);
        data_wdata_o = data_wdata_mem_i << {off, 3'b000};
        push_info    = cur_info;
        if (state == LSU_WAIT_GNT) begin
            req_int      = 1'b1;
            busy_int     = !data_gnt_i;
            data_addr_o  = lat_addr;
            data_we_o    = lat_info.we;
            data_be_o    = lat_be;
            data_wdata_o = lat_wdata;
            push_info    = lat_info;
        end else if (data_req_mem_i) begin
            if (mis_access) begin
                mis_int = 1'b1;
            end else begin
                req_int  = (fifo_count < CW'(MAX_OUTSTANDING));
                busy_int = fifo_full || !data_gnt_i;
            end
        end
    end

    assign push = req_int && data_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= LSU_IDLE;
            lat_addr  <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
            lat_info  <= '0;
        end else if (state == LSU_IDLE) begin
            if (req_int && !data_gnt_i) begin
                state     <= LSU_WAIT_GNT;
                lat_addr  <= data_addr_o;
                lat_be    <= data_be_o;
                lat_wdata <= data_wdata_o;
                lat_info  <= cur_info;
            end
        end else if (data_gnt_i) begin
            state <= LSU_IDLE;
        end
    end

    lsu_resp_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (lsu_pending_t)
    ) u_resp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (push),
        .push_data_i (push_info),
        .pop_i       (data_rvalid_i),
        .pop_data_o  (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // A response with nothing pending is dropped rather than popping garbage.
    assign pop     = data_rvalid_i && !fifo_empty;
    assign shifted = data_rdata_i >> {head.off, 3'b000};

    always_comb begin
        case (head.dtype)
            DT_BYTE: ext = {{(DATA_WIDTH-8){head.sign & shifted[7]}}, shifted[7:0]};
            DT_HALF: ext = {{(DATA_WIDTH-16){head.sign & shifted[15]}}, shifted[15:0]};
            default: ext = shifted;
        endcase
    end

    assign data_rvalid_mem_o = pop && !head.we;
    assign data_rdata_mem_o  = data_rvalid_mem_o ? ext : '0;
    assign data_req_o        = req_int && rst_ni;
    assign lsu_busy_o        = busy_int && rst_ni;
    assign misaligned_o      = mis_int && rst_ni;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_req, data_gnt, data_rvalid, data_we;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_be;
    logic        req_mem, we_mem, sign_mem;
    logic [1:0]  type_mem;
    logic [31:0] wdata_mem, opa, opb;
    logic [31:0] rdata_mem;
    logic        rvalid_mem, busy, misaligned;

    typedef struct {
        logic       we;
        logic [1:0] dt;
        logic       sg;
        logic [1:0] off;
    } pend_t;

    pend_t sb[$];
    int    checks   = 0;
    int    failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .data_req_o          (data_req),
        .data_gnt_i          (data_gnt),
        .data_rvalid_i       (data_rvalid),
        .data_addr_o         (data_addr),
        .data_we_o           (data_we),
        .data_be_o           (data_be),
        .data_wdata_o        (data_wdata),
        .data_rdata_i        (data_rdata),
        .data_req_mem_i      (req_mem),
        .data_we_mem_i       (we_mem),
        .data_type_mem_i     (type_mem),
        .data_sign_ext_mem_i (sign_mem),
        .data_wdata_mem_i    (wdata_mem),
        .operand_a_mem_i     (opa),
        .operand_b_mem_i     (opb),
        .data_rdata_mem_o    (rdata_mem),
        .data_rvalid_mem_o   (rvalid_mem),
        .lsu_busy_o          (busy),
        .misaligned_o        (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [31:0] rd, input logic [1:0] dt,
                                             input logic sg, input logic [1:0] off);
        logic [31:0] s;
        s = rd >> (8 * off);
        case (dt)
            2'b10:   return sg ? {{24{s[7]}}, s[7:0]} : {24'h0, s[7:0]};
            2'b01:   return sg ? {{16{s[15]}}, s[15:0]} : {16'h0, s[15:0]};
            default: return rd;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
        data_gnt    = 1'b0;
        data_rvalid = 1'b0;
    endtask

    task automatic set_mem(input logic we, input logic [1:0] dt, input logic sg,
                           input logic [31:0] a, input logic [31:0] b, input logic [31:0] wd);
        req_mem = 1'b1; we_mem = we; type_mem = dt; sign_mem = sg;
        opa = a; opb = b; wdata_mem = wd;
    endtask

    task automatic push_sb(input logic we, input logic [1:0] dt, input logic sg, input logic [1:0] off);
        pend_t e;
        e.we = we; e.dt = dt; e.sg = sg; e.off = off;
        sb.push_back(e);
    endtask

    task automatic respond(input logic [31:0] rd, input string tag);
        pend_t e;
        data_rvalid = 1'b1;
        data_rdata  = rd;
        #3;
        if (sb.size() == 0) begin
            $display("note: %s rvalid with nothing pending (protocol error, must be ignored)", tag);
            chk({tag, "_rvalid_ignored"}, {31'h0, rvalid_mem}, 32'h0);
            chk({tag, "_rdata_ignored"}, rdata_mem, 32'h0);
        end else begin
            e = sb.pop_front();
            if (e.we) begin
                chk({tag, "_store_silent"}, {31'h0, rvalid_mem}, 32'h0);
            end else begin
                chk({tag, "_rvalid"}, {31'h0, rvalid_mem}, 32'h1);
                chk({tag, "_rdata"}, rdata_mem, exp_load(rd, e.dt, e.sg, e.off));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; data_gnt = 1'b0; data_rvalid = 1'b0; data_rdata = '0;
        set_mem(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'h0);
        data_gnt = 1'b1;
        repeat (2) @(posedge clk);
        #4;
        chk("rst_req", {31'h0, data_req}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_rvalid_mem", {31'h0, rvalid_mem}, 32'h0);
        chk("rst_misaligned", {31'h0, misaligned}, 32'h0);
        chk("rst_rdata_mem", rdata_mem, 32'h0);
        next_cycle();
        rst_n = 1'b1; req_mem = 1'b0;

        // Test 1: signed byte load at offset 3
        next_cycle();
        set_mem(1'b0, 2'b10, 1'b1, 32'h100, 32'h3, 32'h0);
        data_gnt = 1'b1; #3;
        chk("t1_req", {31'h0, data_req}, 32'h1);
        chk("t1_addr", data_addr, 32'h100);
        chk("t1_be", {28'h0, data_be}, 32'h8);
        chk("t1_busy", {31'h0, busy}, 32'h0);
        push_sb(1'b0, 2'b10, 1'b1, 2'd3);
        next_cycle();
        req_mem = 1'b0;
        respond(32'h80FF_FFFF, "t1");
        chk("t1_lb_const", rdata_mem, 32'hFFFF_FF80);

        // Test 2: halfword store, grant withheld for three cycles
        next_cycle();
        set_mem(1'b1, 2'b01, 1'b0, 32'h200, 32'h2, 32'h1234_ABCD);
        for (int i = 0; i < 3; i++) begin
            #3;
            chk($sformatf("t2_req_%0d", i), {31'h0, data_req}, 32'h1);
            chk($sformatf("t2_addr_%0d", i), data_addr, 32'h200);
            chk($sformatf("t2_be_%0d", i), {28'h0, data_be}, 32'hC);
            chk($sformatf("t2_wdata_%0d", i), data_wdata, 32'hABCD_0000);
            chk($sformatf("t2_busy_%0d", i), {31'h0, busy}, 32'h1);
            next_cycle();
        end
        data_gnt = 1'b1; #3;
        chk("t2_gnt_req", {31'h0, data_req}, 32'h1);
        chk("t2_gnt_we", {31'h0, data_we}, 32'h1);
        chk("t2_gnt_busy", {31'h0, busy}, 32'h0);
        push_sb(1'b1, 2'b01, 1'b0, 2'd2);
        next_cycle();
        req_mem = 1'b0;
        respond(32'hCAFE_F00D, "t2");

        // Test 3: misaligned word and illegal type
        next_cycle();
        set_mem(1'b0, 2'b00, 1'b0, 32'h100, 32'h2, 32'h0); #3;
        chk("t3_mis", {31'h0, misaligned}, 32'h1);
        chk("t3_req", {31'h0, data_req}, 32'h0);
        chk("t3_busy", {31'h0, busy}, 32'h0);
        next_cycle();
        set_mem(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0); #3;
        chk("t3_ill_mis", {31'h0, misaligned}, 32'h1);
        chk("t3_ill_req", {31'h0, data_req}, 32'h0);
        chk("t3_ill_busy", {31'h0, busy}, 32'h0);
        next_cycle();
        req_mem = 1'b0; #3;
        chk("t3_mis_clear", {31'h0, misaligned}, 32'h0);

        // Test 4: three back-to-back loads against a 2-deep FIFO
        next_cycle();
        set_mem(1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 32'h0); data_gnt = 1'b1; #3;
        chk("t4_req0", {31'h0, data_req}, 32'h1);
        push_sb(1'b0, 2'b00, 1'b0, 2'd0);
        next_cycle();
        set_mem(1'b0, 2'b00, 1'b0, 32'h304, 32'h0, 32'h0); data_gnt = 1'b1; #3;
        chk("t4_req1", {31'h0, data_req}, 32'h1);
        push_sb(1'b0, 2'b00, 1'b0, 2'd0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            set_mem(1'b0, 2'b00, 1'b0, 32'h308, 32'h0, 32'h0); data_gnt = 1'b1; #3;
            chk($sformatf("t4_full_req_%0d", i), {31'h0, data_req}, 32'h0);
            chk($sformatf("t4_full_busy_%0d", i), {31'h0, busy}, 32'h1);
        end
        next_cycle();
        data_gnt = 1'b1;
        respond(32'h1111_1111, "t4_r0");
        chk("t4_pop_req", {31'h0, data_req}, 32'h0);
        chk("t4_pop_busy", {31'h0, busy}, 32'h1);
        next_cycle();
        data_gnt = 1'b1; #3;
        chk("t4_req2", {31'h0, data_req}, 32'h1);
        chk("t4_req2_addr", data_addr, 32'h308);
        chk("t4_req2_busy", {31'h0, busy}, 32'h0);
        push_sb(1'b0, 2'b00, 1'b0, 2'd0);
        next_cycle();
        req_mem = 1'b0;
        respond(32'h2222_2222, "t4_r1");
        next_cycle();
        respond(32'h3333_3333, "t4_r2");
        chk("t4_r2_const", rdata_mem, 32'h3333_3333);

        // Test 5: push and pop in one cycle, then mixed-size results in order
        next_cycle();
        set_mem(1'b0, 2'b00, 1'b0, 32'h400, 32'h0, 32'h0); data_gnt = 1'b1; #3;
        chk("t5_req_a", {31'h0, data_req}, 32'h1);
        push_sb(1'b0, 2'b00, 1'b0, 2'd0);
        next_cycle();
        set_mem(1'b0, 2'b01, 1'b0, 32'h404, 32'h0, 32'h0); data_gnt = 1'b1;
        respond(32'hAAAA_5555, "t5_a");
        chk("t5_pushpop_req", {31'h0, data_req}, 32'h1);
        push_sb(1'b0, 2'b01, 1'b0, 2'd0);
        next_cycle();
        set_mem(1'b0, 2'b10, 1'b1, 32'h408, 32'h1, 32'h0); data_gnt = 1'b1; #3;
        chk("t5_req_c", {31'h0, data_req}, 32'h1);
        chk("t5_be_c", {28'h0, data_be}, 32'h2);
        push_sb(1'b0, 2'b10, 1'b1, 2'd1);
        next_cycle();
        set_mem(1'b0, 2'b00, 1'b0, 32'h40C, 32'h0, 32'h0); data_gnt = 1'b1; #3;
        chk("t5_full_req", {31'h0, data_req}, 32'h0);
        chk("t5_full_busy", {31'h0, busy}, 32'h1);
        next_cycle();
        req_mem = 1'b0;
        respond(32'h1234_FFFF, "t5_lhu");
        chk("t5_lhu_const", rdata_mem, 32'h0000_FFFF);
        next_cycle();
        respond(32'h0000_8000, "t5_lb");
        chk("t5_lb_const", rdata_mem, 32'hFFFF_FF80);
        next_cycle();
        set_mem(1'b0, 2'b01, 1'b1, 32'h410, 32'h2, 32'h0); data_gnt = 1'b1; #3;
        chk("t5_lh_be", {28'h0, data_be}, 32'hC);
        push_sb(1'b0, 2'b01, 1'b1, 2'd2);
        next_cycle();
        req_mem = 1'b0;
        respond(32'h8001_0000, "t5_lh");
        chk("t5_lh_const", rdata_mem, 32'hFFFF_8001);

        // Test 6: reset while waiting for grant with one response pending
        next_cycle();
        set_mem(1'b0, 2'b00, 1'b0, 32'h500, 32'h0, 32'h0); data_gnt = 1'b1; #3;
        push_sb(1'b0, 2'b00, 1'b0, 2'd0);
        next_cycle();
        set_mem(1'b0, 2'b00, 1'b0, 32'h504, 32'h0, 32'h0); #3;
        chk("t6_wait_busy", {31'h0, busy}, 32'h1);
        next_cycle();
        rst_n = 1'b0; #3;
        chk("t6_rst_req", {31'h0, data_req}, 32'h0);
        chk("t6_rst_busy", {31'h0, busy}, 32'h0);
        chk("t6_rst_mis", {31'h0, misaligned}, 32'h0);
        chk("t6_rst_rvalid", {31'h0, rvalid_mem}, 32'h0);
        chk("t6_rst_rdata", rdata_mem, 32'h0);
        sb.delete();
        next_cycle();
        rst_n = 1'b1; req_mem = 1'b0;
        next_cycle();
        respond(32'hDEAD_BEEF, "t6_stale");
        next_cycle();
        set_mem(1'b0, 2'b00, 1'b0, 32'h600, 32'h4, 32'h0); data_gnt = 1'b1; #3;
        chk("t6_resume_req", {31'h0, data_req}, 32'h1);
        chk("t6_resume_addr", data_addr, 32'h604);
        push_sb(1'b0, 2'b00, 1'b0, 2'd0);
        next_cycle();
        req_mem = 1'b0;
        respond(32'h5A5A_0001, "t6_resume");

        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
